memory_access: RTL and testbench

- MEM stage of the 5-stage pipeline, directly upstream of write_back.
- Takes the EX/MEM bundle and performs loads and stores against an internal synchronous data memory.
- Handles byte, halfword and word accesses, little-endian, with sign or zero extension on loads.
- Registers the MEM/WB bundle (mem_data, ALU_data, MemtoReg, destination register) that write_back consumes.

---
 rtl/memory_access.sv | 126 ++++++++++++
 tb/tb_memory_access.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: MEM stage with a byte-addressable synchronous data memory and the MEM/WB register
module memory_access #(
  parameter int B = 32,
  parameter int D = 5,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [B-1:0] alu_result,
  input  logic [B-1:0] write_data,
  input  logic [D-1:0] rd,
  input  logic         RegWrite,
  input  logic         MemtoReg,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [1:0]   mem_size,
  input  logic         mem_unsigned,
  output logic [B-1:0] mem_data,
  output logic [B-1:0] ALU_data,
  output logic [D-1:0] instruction,
  output logic         RegWrite_out,
  output logic         MemtoReg_out,
  output logic         misaligned
);
  localparam int L = B / 8;
  logic [B-1:0] mem [1 << ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [1:0] off;
  logic err, we;
  logic [L-1:0] be;
  logic [B-1:0] wdata;
  logic [B-1:0] raw_d, raw_q, alu_d, alu_q;
  logic [D-1:0] rd_d, rd_q;
  logic [1:0] off_d, off_q, size_d, size_q;
  logic uns_d, uns_q, ld_d, ld_q, rw_d, rw_q, m2r_d, m2r_q, mis_d, mis_q;
  logic [7:0] b8;
  logic [15:0] h16;
  // decode the address, check alignment, and form lane enables plus lane-aligned store data
  always_comb begin
    idx = alu_result[ADDR_W+1:2];
    off = alu_result[1:0];
    err = (MemRead | MemWrite) & (mem_size == 2'b11 | (mem_size == 2'b10 & off != 2'b00) | (mem_size == 2'b01 & off[0]));
    we = MemWrite & ~err & ~stall & ~flush & ~reset;
    be = mem_size == 2'b00 ? L'(1) << off : mem_size == 2'b01 ? L'(3) << off : '1;
    wdata = write_data << {off, 3'b0};
  end
  // byte-lane writes; untouched lanes keep their contents
  always_ff @(posedge clk)
    if (we) for (int i = 0; i < L; i++) if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  // next MEM/WB contents: bubble on flush, hold on stall, otherwise capture this instruction
  always_comb begin
    raw_d = raw_q;
    alu_d = alu_q;
    rd_d = rd_q;
    off_d = off_q;
    size_d = size_q;
    uns_d = uns_q;
    ld_d = ld_q;
    rw_d = rw_q;
    m2r_d = m2r_q;
    mis_d = mis_q;
    if (flush) begin
      raw_d = '0;
      alu_d = '0;
      rd_d = '0;
      off_d = '0;
      size_d = '0;
      uns_d = 1'b0;
      ld_d = 1'b0;
      rw_d = 1'b0;
      m2r_d = 1'b0;
      mis_d = 1'b0;
    end else if (!stall) begin
      raw_d = mem[idx];
      alu_d = alu_result;
      rd_d = rd;
      off_d = off;
      size_d = mem_size;
      uns_d = mem_unsigned;
      ld_d = MemRead & ~err;
      rw_d = RegWrite & ~err;
      m2r_d = MemtoReg;
      mis_d = err;
    end
  end
  // MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= '0;
      alu_q <= '0;
      rd_q <= '0;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      ld_q <= 1'b0;
      rw_q <= 1'b0;
      m2r_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      raw_q <= raw_d;
      alu_q <= alu_d;
      rd_q <= rd_d;
      off_q <= off_d;
      size_q <= size_d;
      uns_q <= uns_d;
      ld_q <= ld_d;
      rw_q <= rw_d;
      m2r_q <= m2r_d;
      mis_q <= mis_d;
    end
  end
  // select and extend the loaded lanes from the registered raw word
  always_comb begin
    b8 = raw_q[{off_q, 3'b0} +: 8];
    h16 = raw_q[{off_q[1], 4'b0} +: 16];
    mem_data = !ld_q ? '0 : size_q == 2'b00 ? {{(B-8){~uns_q & b8[7]}}, b8} :
               size_q == 2'b01 ? {{(B-16){~uns_q & h16[15]}}, h16} : raw_q;
  end
  assign ALU_data = alu_q;
  assign instruction = rd_q;
  assign RegWrite_out = rw_q;
  assign MemtoReg_out = m2r_q;
  assign misaligned = mis_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed load/store, alignment, stall, flush and reset checks
module tb_memory_access;
  logic clk = 1'b0, reset, stall, flush;
  logic [31:0] alu_result, write_data, mem_data, ALU_data;
  logic [4:0] rd, instruction;
  logic RegWrite, MemtoReg, MemRead, MemWrite, mem_unsigned;
  logic [1:0] mem_size;
  logic RegWrite_out, MemtoReg_out, misaligned;
  int n_cmp = 0, n_bad = 0;

  memory_access dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .alu_result(alu_result), .write_data(write_data), .rd(rd),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_data(mem_data), .ALU_data(ALU_data), .instruction(instruction),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] d,
                    input logic rw, input logic m2r);
    MemRead = r; MemWrite = w; mem_size = sz; mem_unsigned = u;
    alu_result = a; write_data = wd; rd = d; RegWrite = rw; MemtoReg = m2r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a);
    op(1, 0, sz, u, a, 32'h0, 5'd1, 1, 1);
    step();
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    op(0, 1, sz, 0, a, wd, 5'd0, 0, 0);
    step();
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    op(0, 1, 2'b10, 0, 32'h40, 32'h1111_1111, 5'd9, 1, 1);
    step(); step();
    chk("rst_mem_data", mem_data, 0);
    chk("rst_alu", ALU_data, 0);
    chk("rst_inst", {27'd0, instruction}, 0);
    chk("rst_flags", {29'd0, RegWrite_out, MemtoReg_out, misaligned}, 0);
    reset = 0;
    st(2'b10, 32'h10, 32'hDEAD_BEEF);
    chk("st_alu", ALU_data, 32'h10);
    chk("st_mis", {31'd0, misaligned}, 0);
    op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd5, 1, 1);
    step();
    chk("lw_data", mem_data, 32'hDEAD_BEEF);
    chk("lw_inst", {27'd0, instruction}, 5);
    chk("lw_flags", {30'd0, RegWrite_out, MemtoReg_out}, 32'h3);
    st(2'b00, 32'h11, 32'hFFFF_FF80);
    chk("sb_no_load", mem_data, 0);
    ld(2'b00, 0, 32'h11); chk("lb_signed", mem_data, 32'hFFFF_FF80);
    ld(2'b00, 1, 32'h11); chk("lb_unsigned", mem_data, 32'h0000_0080);
    ld(2'b10, 0, 32'h10); chk("lw_after_sb", mem_data, 32'hDEAD_80EF);
    ld(2'b01, 0, 32'h12); chk("lh_signed", mem_data, 32'hFFFF_DEAD);
    ld(2'b01, 1, 32'h12); chk("lh_unsigned", mem_data, 32'h0000_DEAD);
    ld(2'b01, 0, 32'h1012); chk("lh_alias", mem_data, 32'hFFFF_DEAD);
    chk("lh_alias_alu", ALU_data, 32'h1012);
    st(2'b10, 32'h14, 32'h0);
    st(2'b01, 32'h16, 32'hAAAA_5A5A);
    ld(2'b10, 0, 32'h14); chk("sh_lanes", mem_data, 32'h5A5A_0000);
    st(2'b10, 32'h20, 32'hCAFE_F00D);
    op(0, 1, 2'b10, 0, 32'h22, 32'h1234_5678, 5'd4, 1, 0);
    step();
    chk("mis_sw_flag", {31'd0, misaligned}, 1);
    chk("mis_sw_rw", {31'd0, RegWrite_out}, 0);
    chk("mis_sw_alu", ALU_data, 32'h22);
    ld(2'b10, 0, 32'h20);
    chk("mis_sw_clear", {31'd0, misaligned}, 0);
    chk("mis_sw_nowrite", mem_data, 32'hCAFE_F00D);
    ld(2'b01, 0, 32'h13);
    chk("mis_lh_flag", {31'd0, misaligned}, 1);
    chk("mis_lh_data", mem_data, 0);
    chk("mis_lh_rw", {31'd0, RegWrite_out}, 0);
    ld(2'b11, 0, 32'h10); chk("rsv_size_flag", {31'd0, misaligned}, 1);
    st(2'b10, 32'h30, 32'h0);
    st(2'b10, 32'h34, 32'h0);
    op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd7, 1, 1);
    step();
    op(0, 1, 2'b10, 0, 32'h30, 32'h0BAD_CAFE, 5'd9, 0, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data", mem_data, 32'hDEAD_80EF);
      chk("stall_inst", {27'd0, instruction}, 7);
      chk("stall_alu", ALU_data, 32'h10);
    end
    stall = 0;
    step();
    chk("unstall_alu", ALU_data, 32'h30);
    chk("unstall_inst", {27'd0, instruction}, 9);
    ld(2'b10, 0, 32'h30); chk("stall_store", mem_data, 32'h0BAD_CAFE);
    op(0, 1, 2'b10, 0, 32'h34, 32'h1111_1111, 5'd0, 0, 0);
    stall = 1;
    step();
    stall = 0;
    ld(2'b10, 0, 32'h34); chk("stall_nowrite", mem_data, 0);
    ld(2'b10, 0, 32'h30);
    op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd3, 1, 1);
    flush = 1;
    step();
    chk("flush_data", mem_data, 0);
    chk("flush_alu", ALU_data, 0);
    chk("flush_bits", {26'd0, instruction, RegWrite_out, MemtoReg_out, misaligned}, 0);
    op(0, 1, 2'b10, 0, 32'h30, 32'hFFFF_FFFF, 5'd0, 0, 0);
    step();
    flush = 0;
    ld(2'b10, 0, 32'h30); chk("flush_nowrite", mem_data, 32'h0BAD_CAFE);
    op(1, 1, 2'b10, 0, 32'h10, 32'h0102_0304, 5'd2, 1, 1);
    step();
    chk("rw_old", mem_data, 32'hDEAD_80EF);
    ld(2'b10, 0, 32'h10); chk("rw_new", mem_data, 32'h0102_0304);
    st(2'b10, 32'h40, 32'hAAAA_AAAA);
    reset = 1;
    st(2'b10, 32'h40, 32'h1111_1111);
    reset = 0;
    ld(2'b10, 0, 32'h40); chk("rst_nowrite", mem_data, 32'hAAAA_AAAA);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
